// File: rtl/adder_pkg.sv
// Shared widths for the segmented adder and its downstream output register stage.
package adder_pkg;

  localparam int unsigned ADDER_WIDTH  = 32;
  localparam int unsigned ADDER_SEG    = 8;
  localparam int unsigned ADDER_STAGES = ADDER_WIDTH / ADDER_SEG;

endpackage : adder_pkg

// File: rtl/adder_seg.sv
// One pipeline stage: adds operand segment K plus the incoming carry and
// forwards the operands and the partially assembled sum to the next stage.
module adder_seg
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH,
  parameter int unsigned SEG   = ADDER_SEG,
  parameter int unsigned K     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic             i_carry,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_sum,
  output logic             o_valid,
  output logic             o_carry,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic [WIDTH-1:0] o_sum
);

  localparam int unsigned SW = SEG + 1;
  localparam int unsigned LO = K * SEG;
  localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}}) << LO;

  logic [SEG-1:0]   w_a_seg;
  logic [SEG-1:0]   w_b_seg;
  logic [SW-1:0]    w_add;
  logic [WIDTH-1:0] w_sum_next;

  logic             r_valid;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;

  assign w_a_seg    = i_a[LO +: SEG];
  assign w_b_seg    = i_b[LO +: SEG];
  assign w_add      = SW'(w_a_seg) + SW'(w_b_seg) + SW'(i_carry);
  assign w_sum_next = (i_sum & ~SEG_MASK) | (WIDTH'(w_add[SEG-1:0]) << LO);

  // Valid advances with en; data only loads behind a valid operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_carry <= w_add[SEG];
        r_a     <= i_a;
        r_b     <= i_b;
        r_sum   <= w_sum_next;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_carry = r_carry;
  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_sum   = r_sum;

endmodule : adder_seg

// File: rtl/adder_pipe.sv
// Segmented pipelined ripple adder: {co, sum} = a + b + ci, one stage per SEG bits.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH,
  parameter int unsigned SEG   = ADDER_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int unsigned STAGES = WIDTH / SEG;

  // Index 0 is the pipeline input; index k+1 is the output of stage k.
  logic             w_valid [STAGES+1];
  logic             w_carry [STAGES+1];
  logic [WIDTH-1:0] w_a     [STAGES+1];
  logic [WIDTH-1:0] w_b     [STAGES+1];
  logic [WIDTH-1:0] w_sum   [STAGES+1];
  logic             w_unused;

  assign w_valid[0] = in_valid;
  assign w_carry[0] = ci;
  assign w_a[0]     = a;
  assign w_b[0]     = b;
  assign w_sum[0]   = '0;

  // One stage per segment; operands and partial sums ride along so results emerge aligned.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_seg #(
      .WIDTH (WIDTH),
      .SEG   (SEG),
      .K     (k)
    ) u_seg (
      .clk     (clk),
      .rst     (rst),
      .i_en    (en),
      .i_valid (w_valid[k]),
      .i_carry (w_carry[k]),
      .i_a     (w_a[k]),
      .i_b     (w_b[k]),
      .i_sum   (w_sum[k]),
      .o_valid (w_valid[k+1]),
      .o_carry (w_carry[k+1]),
      .o_a     (w_a[k+1]),
      .o_b     (w_b[k+1]),
      .o_sum   (w_sum[k+1])
    );
  end

  assign out_valid = w_valid[STAGES];
  assign sum       = w_sum[STAGES];
  assign co        = w_carry[STAGES];

  // Operands leaving the last stage have no consumer.
  assign w_unused = ^{w_a[STAGES], w_b[STAGES]};

endmodule : adder_pipe

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: directed cases plus a randomized run against
// a model that tracks results by enabled-edge count.
module tb_adder_pipe;
  import adder_pkg::*;

  localparam int unsigned W      = ADDER_WIDTH;
  localparam int unsigned STAGES = ADDER_STAGES;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         co;

  int n_pass  = 0;
  int n_total = 0;

  adder_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .sum       (sum),
    .co        (co)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Model: each enabled edge pushes the full (W+1)-bit result of whatever was
  // presented; the result visible at the output is the one pushed STAGES-1
  // enabled edges earlier. Stalls and bubbles hold the last reported result.
  typedef struct packed {
    logic         v;
    logic [W:0]   r;
  } ent_t;

  ent_t       hist[$];
  ent_t       e_new;
  logic       exp_v    = 1'b0;
  logic [W:0] exp_last = '0;
  logic       ready    = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      for (int i = 0; i < int'(STAGES); i++) hist.push_back('0);
      exp_v    = 1'b0;
      exp_last = '0;
      ready    = 1'b1;
    end else if (en && ready) begin
      e_new.v = in_valid;
      e_new.r = (W+1)'(a) + (W+1)'(b) + (W+1)'(ci);
      hist.push_front(e_new);
      void'(hist.pop_back());
      exp_v = hist[STAGES-1].v;
      if (exp_v) exp_last = hist[STAGES-1].r;
    end
  end

  // Every cycle after the first reset the outputs are compared with the model.
  always @(negedge clk) begin
    if (ready) begin
      check("out_valid", 64'(out_valid), 64'(exp_v));
      check("sum",       64'(sum),       64'(exp_last[W-1:0]));
      check("co",        64'(co),        64'(exp_last[W]));
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci);
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    ci       = tci;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_after(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                              input logic tci, input logic [W-1:0] esum, input logic eco);
    issue(ta, tb, tci);
    for (int i = 1; i < int'(STAGES); i++) begin
      check({name, "_early_valid"}, 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_sum"},   64'(sum),       64'(esum));
    check({name, "_co"},    64'(co),        64'(eco));
    idle(STAGES + 2);
  endtask

  int lat;

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_sum",   64'(sum),       64'd0);
    check("rst_co",    64'(co),        64'd0);
    rst = 1'b0; en = 1'b1;
    @(negedge clk);

    // Basic add and literal pin on the model
    expect_after("add5p3", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0);
    check("model_add5p3", 64'(exp_last), 64'h0_0000_0008);

    // Full carry ripple through every segment
    expect_after("ripple_ci", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
    expect_after("ripple_b1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
    check("model_ripple", 64'(exp_last), 64'h1_0000_0000);

    // Back-to-back operations
    issue(32'h0000_0001, 32'h0000_0001, 1'b0);
    issue(32'h8000_0000, 32'h8000_0000, 1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < int'(STAGES) - 3; i++) @(negedge clk);
    check("b2b0_valid", 64'(out_valid), 64'd1);
    check("b2b0_res",   64'({co, sum}), 64'h0_0000_0002);
    @(negedge clk);
    check("b2b1_valid", 64'(out_valid), 64'd1);
    check("b2b1_res",   64'({co, sum}), 64'h1_0000_0000);
    @(negedge clk);
    check("b2b2_valid", 64'(out_valid), 64'd1);
    check("b2b2_res",   64'({co, sum}), 64'h1_FFFF_FFFE);
    check("model_b2b2", 64'(exp_last),  64'h1_FFFF_FFFE);
    @(negedge clk);
    check("b2b_end_valid", 64'(out_valid), 64'd0);
    idle(STAGES + 2);

    // Stall mid-flight: latency stretches by the stall length
    lat = 0;
    issue(32'h1234_5678, 32'h1111_1111, 1'b0);
    lat++;
    @(negedge clk); lat++;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); lat++;
      check("stall_valid", 64'(out_valid), 64'd0);
    end
    en = 1'b1;
    while (!out_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    check("stall_latency", 64'(lat), 64'd7);
    check("stall_res",     64'({co, sum}), 64'h0_2345_6789);
    idle(STAGES + 2);

    // Reset mid-flight discards both operations
    issue(32'h0000_00AA, 32'h0000_0055, 1'b0);
    issue(32'h0000_1000, 32'h0000_2000, 1'b1);
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < int'(STAGES) + 3; i++) begin
      check("rstmid_valid", 64'(out_valid), 64'd0);
      check("rstmid_res",   64'({co, sum}), 64'd0);
      @(negedge clk);
    end

    // Randomized regression with bubbles, stalls and rare resets
    for (int i = 0; i < 10000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      en       = ($urandom_range(0, 4) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       a = '1;
        1:       a = '0;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = '1;
        1:       b = 32'h0000_0001;
        default: b = $urandom;
      endcase
      ci = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    rst = 1'b0; en = 1'b1;
    idle(STAGES + 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_adder_pipe

// File: doc/adder_pipe.md
# adder_pipe

Segmented, pipelined carry-ripple adder computing `{co, sum} = a + b + ci` for `WIDTH`-bit operands, `SEG` bits per stage. It sits directly upstream of the sum/carry output register stage: `sum` drives that stage's `si` and `co` drives its `ci`. It accepts one operation per enabled cycle and produces one result per enabled cycle after a fixed latency of `WIDTH/SEG` enabled cycles.

## Interface
Parameters:
- `WIDTH`, default 32: operand and sum width. Must be a multiple of `SEG`.
- `SEG`, default 8: bits added per pipeline stage. `STAGES = WIDTH/SEG`.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `en`, input, 1: pipeline advance. When low, every register holds.
- `in_valid`, input, 1: `a`, `b` and `ci` carry a new operation. Sampled only when `en` = 1.
- `a`, input, `WIDTH`: operand A.
- `b`, input, `WIDTH`: operand B.
- `ci`, input, 1: carry-in.
- `out_valid`, output, 1: `sum` and `co` hold a new result.
- `sum`, output, `WIDTH`: result bits `[WIDTH-1:0]`.
- `co`, output, 1: carry-out (bit `WIDTH` of the full result).

## Operation
- Stage k (0..`STAGES-1`) adds operand segment `[k*SEG +: SEG]` plus the carry registered by stage k-1. Stage 0 uses `ci` as its carry.
- Each stage performs a `SEG+1`-bit add. The low `SEG` bits are the sum segment and the MSB is the carry passed to stage k+1.
- Unconsumed upper operand segments travel down the pipeline with the operation. Completed lower sum segments also travel down the pipeline, so every result emerges aligned.
- Result: `{co, sum} = a + b + ci` exactly, modulo 2^(WIDTH+1). There is no overflow flag.
- Each stage has one valid bit. The stage-0 valid loads `in_valid`; stage k's valid loads stage k-1's valid. `out_valid` is the last stage's valid bit.
- Stage data registers load only when their incoming valid is 1 and `en` = 1. On a bubble, data holds its previous value and only the valid bit clears. While `out_valid` = 0, `sum` and `co` therefore keep the last result.
- Priority order: `rst` > `en`. `rst` = 1 at an edge clears everything regardless of `en`.

## Timing
- Reset values: `out_valid` = 0, `sum` = 0, `co` = 0. All internal valid bits, carries and data registers are 0.
- Latency: an operation accepted at enabled edge N appears with `out_valid` = 1 after enabled edge N+`STAGES`-1. With `en` held high and defaults, that is 4 cycles after acceptance.
- Throughput: one operation per enabled cycle. Back-to-back `in_valid` needs no gap.
- `en` low for M cycles: all registers freeze and latency stretches by exactly M cycles. `out_valid` and `sum` stay stable during the stall and are not re-reported as new.
- Reset mid-operation: all in-flight operations are discarded at the reset edge. The first post-reset result comes only from an operation accepted after `rst` deasserts.
- `in_valid` while `rst` = 1 is ignored.
- `SEG` = `WIDTH` is legal: a single stage with 1-cycle latency.
- The carry chain spans at most one `SEG+1`-bit adder per cycle, with no cross-stage combinational path.

## Structure
- Shared package `adder_pkg`:
  - Default constants `ADDER_WIDTH` = 32 and `ADDER_SEG` = 8.
  - The derived `ADDER_STAGES`.
  - These are shared with the downstream output register stage so the widths always match.
- Sub-module `adder_seg`: one pipeline stage. It contains:
  - the `SEG+1`-bit add;
  - the valid bit;
  - the carry register;
  - the delayed-operand and partial-sum registers.
- `adder_pipe` instantiates `STAGES` copies of `adder_seg` in a generate loop and handles the operand and partial-sum alignment.

## Test plan
- Reset, then `a` = 0x0000_0005, `b` = 0x0000_0003, `ci` = 0, `en` = 1 → exactly 4 cycles later: `out_valid` = 1, `sum` = 0x0000_0008, `co` = 0.
- Full carry ripple across all segments: `a` = 0xFFFF_FFFF, `b` = 0x0000_0000, `ci` = 1 → `sum` = 0x0000_0000, `co` = 1. Also `a` = 0xFFFF_FFFF, `b` = 0x0000_0001, `ci` = 0 → same result.
- Back-to-back: issue 0x1+0x1, 0x8000_0000+0x8000_0000, 0xFFFF_FFFF+0xFFFF_FFFF on consecutive cycles → consecutive results {0, 0x2}, {1, 0x0}, {1, 0xFFFF_FFFE} with `out_valid` high for 3 consecutive cycles.
- Stall: accept 0x1234_5678+0x1111_1111, then hold `en` = 0 for 3 cycles mid-flight → result 0x2345_6789, `co` = 0 appears 7 cycles after acceptance. `sum` is unchanged during the stall.
- Reset mid-flight: accept 2 operations, assert `rst` for 1 cycle two cycles later → `out_valid` never rises for either operation, and `sum` = 0, `co` = 0 until a new operation completes.
- Random regression: 10,000 random `a`, `b`, `ci`, `in_valid` and `en` values, compared against a reference model of the 33-bit sum with matching latency, bubble handling and stall handling.
